mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access pipeline stage: it consumes the execute stage's registered outputs and turns loads and stores into a valid/ready request to the data cache. It raises the data-cache stall that freezes the upstream stages while an access is outstanding. It aligns and sign- or zero-extends load data, then registers the MEM/WB outputs for writeback.

## Interface
Parameters:
- BUS_DATA_WIDTH, 64, datapath and address width.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- inResult  in  64  execute-stage result; this is the access address for memory operations.
- inDataReg2  in  64  store data, right-aligned.
- inMemRead, inMemWrite  in  1  load / store operation.
- inLoadType  in  3  000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu; 111 treated as ld.
- inStoreType  in  2  00 sb, 01 sh, 10 sw, 11 sd.
- inRegWrite, inMemOrReg, inEcall  in  1  passthrough controls.
- inDestRegister  in  5  destination register.
- inPc  in  64  instruction PC, passthrough.
- in_stall_from_icache  in  1  global freeze from the instruction cache.
- outReqValid  out  1  data-cache request valid.
- inReqReady  in  1  data-cache accepts the request.
- outReqAddr  out  64  address, forced to a doubleword boundary ({inResult[63:3],3'b0}).
- outReqWrite  out  1  1 = store.
- outReqWdata  out  64  store data placed in its byte lanes.
- outReqWstrb  out  8  byte enables.
- inRespValid  in  1  read data returned or write acknowledged.
- inRespData  in  64  doubleword containing the address.
- out_stall_from_dcache  out  1  freezes the upstream pipeline.
- outRegWrite, outMemOrReg, outEcall, outMisaligned  out  1  MEM/WB controls.
- outDestRegister  out  5  MEM/WB destination register.
- outAluResult, outMemData, outPc  out  64  MEM/WB data.

## Operation
- memOp = inMemRead | inMemWrite. inMemRead takes priority if both are set.
- Byte offset off = inResult[2:0].
- Misaligned access:
  - lh/lhu/sh with off[0] set;
  - lw/lwu/sw with off[1:0] nonzero;
  - ld/sd with off nonzero.
  - A misaligned access issues no request and does not stall. It registers outMisaligned=1 and outRegWrite=0.
- FSM has three states: IDLE, WAIT, DONE.
  - IDLE: outReqValid = aligned memOp. On inReqReady, go to WAIT. Otherwise stay in IDLE; outReqValid stays high and the request fields stay stable.
  - WAIT: outReqValid=0. On inRespValid, capture the extracted load data into a holding register and go to DONE.
  - DONE: hold until in_stall_from_icache=0, then go to IDLE.
- out_stall_from_dcache = aligned memOp && state != DONE. This is combinational.
- Store formatting:
  - wdata = store data replicated across lanes (byte x8, half x4, word x2, dword x1).
  - wstrb = base mask (0x01, 0x03, 0x0F, 0xFF) << off.
- Load extraction:
  - shifted = inRespData >> (8*off).
  - Take the low 8/16/32/64 bits; sign-extend for lb/lh/lw, zero-extend for lbu/lhu/lwu.
- MEM/WB register:
  - Updates when in_stall_from_icache=0 and out_stall_from_dcache=0. Otherwise it holds.
  - Captures controls, inResult into outAluResult, holding register into outMemData (loads only; otherwise 0), and outMisaligned.
  - Stores and non-memory operations pass straight through.
- Reset is asynchronous, and it also applies mid-access: state goes to IDLE and every output register, including the holding register, clears to 0.
  - Outputs then read outReqValid=0, out_stall_from_dcache=0 (until an aligned memOp is presented), and all MEM/WB outputs 0.
  - A response arriving after reset is ignored in IDLE.
- inRespValid is ignored in IDLE and in DONE.

## Timing
- Non-memory operation: one-cycle latency to the MEM/WB outputs, no stall.
- Load or store with ready in the same cycle and the response one cycle later:
  - cycle 0: IDLE, request accepted;
  - cycle 1: WAIT, response arrives;
  - cycle 2: DONE, stall low, MEM/WB captures at the end of the cycle.
  - The stall is high in cycles 0-1, so the minimum occupancy is 3 cycles.
- Each extra cycle without inReqReady, and each extra cycle of response latency, adds one stall cycle.
- Upstream holds its inputs stable while out_stall_from_dcache=1.
- An icache stall in DONE extends DONE. The access is never reissued.
- Back-to-back memory operations: the second one enters IDLE in the cycle after DONE and follows the same sequence.

## Test plan
- Addi-type passthrough:
  - Stimulus: inResult=0x1234, inRegWrite=1, dest=5.
  - Required: the next cycle gives outAluResult=0x1234, outRegWrite=1, outDestRegister=5; stall never high.
- lb sign-extension:
  - Stimulus: lb at 0x1003, inRespData=0x0000_0000_8000_0000.
  - Required: outReqAddr=0x1000; outMemData=0xFFFF_FFFF_FFFF_FF80; stall high for exactly 2 cycles with zero-wait ready/response.
- sh formatting:
  - Stimulus: sh at 0x2006, data 0xBEEF.
  - Required: outReqWstrb=0xC0, outReqWdata=0xBEEF_BEEF_BEEF_BEEF, outReqWrite=1.
- Ready held low 3 cycles on an ld:
  - Required: request fields stable throughout; stall high 5 cycles total; the request is accepted exactly once.
- Misaligned lw at 0x3002:
  - Required: outReqValid stays 0; the next cycle gives outMisaligned=1 and outRegWrite=0.
- Reset asserted in WAIT:
  - Required: immediate IDLE with all outputs 0; a response pulse arriving after reset causes no MEM/WB update.
- icache stall during DONE:
  - Required: MEM/WB holds and no second request is issued.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access stage: issues D-cache requests, stalls upstream while an
// access is in flight, extracts load data and registers the MEM/WB bundle.
module mem_access_stage #(
  parameter int BUS_DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [BUS_DATA_WIDTH-1:0] inResult,
  input  logic [BUS_DATA_WIDTH-1:0] inDataReg2,
  input  logic                      inMemRead,
  input  logic                      inMemWrite,
  input  logic [2:0]                inLoadType,
  input  logic [1:0]                inStoreType,
  input  logic                      inRegWrite,
  input  logic                      inMemOrReg,
  input  logic                      inEcall,
  input  logic [4:0]                inDestRegister,
  input  logic [BUS_DATA_WIDTH-1:0] inPc,
  input  logic                      in_stall_from_icache,
  output logic                      outReqValid,
  input  logic                      inReqReady,
  output logic [BUS_DATA_WIDTH-1:0] outReqAddr,
  output logic                      outReqWrite,
  output logic [BUS_DATA_WIDTH-1:0] outReqWdata,
  output logic [7:0]                outReqWstrb,
  input  logic                      inRespValid,
  input  logic [BUS_DATA_WIDTH-1:0] inRespData,
  output logic                      out_stall_from_dcache,
  output logic                      outRegWrite,
  output logic                      outMemOrReg,
  output logic                      outEcall,
  output logic                      outMisaligned,
  output logic [4:0]                outDestRegister,
  output logic [BUS_DATA_WIDTH-1:0] outAluResult,
  output logic [BUS_DATA_WIDTH-1:0] outMemData,
  output logic [BUS_DATA_WIDTH-1:0] outPc
);

  localparam int W = BUS_DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e state_q, state_d;
  logic [W-1:0] hold_q, hold_d;

  logic         mem_op;
  logic         mis;
  logic         op_ok;
  logic [2:0]   off;
  logic [1:0]   size;
  logic         uns;
  logic [W-1:0] shifted;
  logic [W-1:0] ld_ext;
  logic         mwb_en;

  assign mem_op = inMemRead | inMemWrite;
  assign off    = inResult[2:0];
  // loads win over stores when both flags are set
  assign size   = inMemRead ? inLoadType[1:0] : inStoreType;

  always_comb begin
    mis = 1'b0;
    case (size)
      2'd0: mis = 1'b0;
      2'd1: mis = off[0];
      2'd2: mis = |off[1:0];
      2'd3: mis = |off;
      default: mis = 1'b0;
    endcase
    mis = mis & mem_op;
  end

  assign op_ok = mem_op & ~mis;

  assign outReqAddr  = {inResult[W-1:3], 3'b000};
  assign outReqWrite = inMemWrite & ~inMemRead;
  assign outReqValid = op_ok & (state_q == S_IDLE);

  assign out_stall_from_dcache = op_ok & (state_q != S_DONE);

  always_comb begin
    outReqWdata = inDataReg2;
    outReqWstrb = 8'h00;
    case (inStoreType)
      2'd0: begin
        outReqWdata = {8{inDataReg2[7:0]}};
        outReqWstrb = 8'h01 << off;
      end
      2'd1: begin
        outReqWdata = {4{inDataReg2[15:0]}};
        outReqWstrb = 8'h03 << off;
      end
      2'd2: begin
        outReqWdata = {2{inDataReg2[31:0]}};
        outReqWstrb = 8'h0F << off;
      end
      default: begin
        outReqWdata = inDataReg2;
        outReqWstrb = 8'hFF;
      end
    endcase
    if (!outReqWrite) outReqWstrb = 8'h00;
  end

  assign shifted = inRespData >> {off, 3'b000};
  assign uns     = inLoadType[2];

  always_comb begin
    ld_ext = shifted;
    case (inLoadType[1:0])
      2'd0: ld_ext = {{(W-8){~uns & shifted[7]}}, shifted[7:0]};
      2'd1: ld_ext = {{(W-16){~uns & shifted[15]}}, shifted[15:0]};
      2'd2: ld_ext = {{(W-32){~uns & shifted[31]}}, shifted[31:0]};
      default: ld_ext = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      S_IDLE: if (op_ok && inReqReady) state_d = S_WAIT;
      S_WAIT: begin
        if (inRespValid) begin
          hold_d  = ld_ext;
          state_d = S_DONE;
        end
      end
      S_DONE: if (!in_stall_from_icache) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign mwb_en = ~in_stall_from_icache & ~out_stall_from_dcache;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outRegWrite     <= 1'b0;
      outMemOrReg     <= 1'b0;
      outEcall        <= 1'b0;
      outMisaligned   <= 1'b0;
      outDestRegister <= '0;
      outAluResult    <= '0;
      outMemData      <= '0;
      outPc           <= '0;
    end else if (mwb_en) begin
      outRegWrite     <= inRegWrite & ~mis;
      outMemOrReg     <= inMemOrReg;
      outEcall        <= inEcall;
      outMisaligned   <= mis;
      outDestRegister <= inDestRegister;
      outAluResult    <= inResult;
      outMemData      <= (inMemRead & ~mis) ? hold_q : '0;
      outPc           <= inPc;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: passthrough, loads, stores,
// ready back-pressure, misalignment, mid-access reset and icache freeze.
module tb_mem_access_stage;

  logic        clk;
  logic        reset_n;
  logic [63:0] inResult;
  logic [63:0] inDataReg2;
  logic        inMemRead;
  logic        inMemWrite;
  logic [2:0]  inLoadType;
  logic [1:0]  inStoreType;
  logic        inRegWrite;
  logic        inMemOrReg;
  logic        inEcall;
  logic [4:0]  inDestRegister;
  logic [63:0] inPc;
  logic        in_stall_from_icache;
  logic        outReqValid;
  logic        inReqReady;
  logic [63:0] outReqAddr;
  logic        outReqWrite;
  logic [63:0] outReqWdata;
  logic [7:0]  outReqWstrb;
  logic        inRespValid;
  logic [63:0] inRespData;
  logic        out_stall_from_dcache;
  logic        outRegWrite;
  logic        outMemOrReg;
  logic        outEcall;
  logic        outMisaligned;
  logic [4:0]  outDestRegister;
  logic [63:0] outAluResult;
  logic [63:0] outMemData;
  logic [63:0] outPc;

  int checks;
  int errors;

  mem_access_stage #(.BUS_DATA_WIDTH(64)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .inResult             (inResult),
    .inDataReg2           (inDataReg2),
    .inMemRead            (inMemRead),
    .inMemWrite           (inMemWrite),
    .inLoadType           (inLoadType),
    .inStoreType          (inStoreType),
    .inRegWrite           (inRegWrite),
    .inMemOrReg           (inMemOrReg),
    .inEcall              (inEcall),
    .inDestRegister       (inDestRegister),
    .inPc                 (inPc),
    .in_stall_from_icache (in_stall_from_icache),
    .outReqValid          (outReqValid),
    .inReqReady           (inReqReady),
    .outReqAddr           (outReqAddr),
    .outReqWrite          (outReqWrite),
    .outReqWdata          (outReqWdata),
    .outReqWstrb          (outReqWstrb),
    .inRespValid          (inRespValid),
    .inRespData           (inRespData),
    .out_stall_from_dcache(out_stall_from_dcache),
    .outRegWrite          (outRegWrite),
    .outMemOrReg          (outMemOrReg),
    .outEcall             (outEcall),
    .outMisaligned        (outMisaligned),
    .outDestRegister      (outDestRegister),
    .outAluResult         (outAluResult),
    .outMemData           (outMemData),
    .outPc                (outPc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    inResult             = '0;
    inDataReg2           = '0;
    inMemRead            = 1'b0;
    inMemWrite           = 1'b0;
    inLoadType           = '0;
    inStoreType          = '0;
    inRegWrite           = 1'b0;
    inMemOrReg           = 1'b0;
    inEcall              = 1'b0;
    inDestRegister       = '0;
    inPc                 = '0;
    in_stall_from_icache = 1'b0;
    inReqReady           = 1'b0;
    inRespValid          = 1'b0;
    inRespData           = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_in();
    tick();
    tick();
    checks++;
    if ({outRegWrite, outMemOrReg, outEcall, outMisaligned} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b want 0000",
               {outRegWrite, outMemOrReg, outEcall, outMisaligned});
    end
    checks++;
    if (outAluResult !== 64'h0 || outMemData !== 64'h0 || outPc !== 64'h0) begin
      errors++;
      $display("FAIL reset_data alu %h mem %h pc %h want 0",
               outAluResult, outMemData, outPc);
    end
    checks++;
    if (outReqValid !== 1'b0 || out_stall_from_dcache !== 1'b0) begin
      errors++;
      $display("FAIL reset_req valid %b stall %b want 0 0",
               outReqValid, out_stall_from_dcache);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_passthrough();
    clear_in();
    inResult       = 64'h1234;
    inRegWrite     = 1'b1;
    inDestRegister = 5'd5;
    inPc           = 64'h400;
    #1;
    checks++;
    if (out_stall_from_dcache !== 1'b0 || outReqValid !== 1'b0) begin
      errors++;
      $display("FAIL pass_stall stall %b valid %b want 0 0",
               out_stall_from_dcache, outReqValid);
    end
    tick();
    checks++;
    if (outAluResult !== 64'h1234 || outRegWrite !== 1'b1 ||
        outDestRegister !== 5'd5 || outPc !== 64'h400) begin
      errors++;
      $display("FAIL pass_mwb alu %h rw %b rd %0d pc %h want 1234 1 5 400",
               outAluResult, outRegWrite, outDestRegister, outPc);
    end
  endtask

  task automatic test_lb();
    int scnt;
    scnt = 0;
    clear_in();
    inResult   = 64'h1003;
    inMemRead  = 1'b1;
    inLoadType = 3'b000;
    inRegWrite = 1'b1;
    inDestRegister = 5'd9;
    inReqReady = 1'b1;
    #1;
    if (out_stall_from_dcache) scnt++;
    checks++;
    if (outReqAddr !== 64'h1000 || outReqValid !== 1'b1 || outReqWrite !== 1'b0) begin
      errors++;
      $display("FAIL lb_req addr %h valid %b wr %b want 1000 1 0",
               outReqAddr, outReqValid, outReqWrite);
    end
    tick();
    inReqReady  = 1'b0;
    inRespValid = 1'b1;
    inRespData  = 64'h0000_0000_8000_0000;
    #1;
    if (out_stall_from_dcache) scnt++;
    tick();
    inRespValid = 1'b0;
    #1;
    if (out_stall_from_dcache) scnt++;
    tick();
    checks++;
    if (scnt != 2) begin
      errors++;
      $display("FAIL lb_stall cycles %0d want 2", scnt);
    end
    checks++;
    if (outMemData !== 64'hFFFF_FFFF_FFFF_FF80 || outDestRegister !== 5'd9) begin
      errors++;
      $display("FAIL lb_data got %h rd %0d want ffffffffffffff80 9",
               outMemData, outDestRegister);
    end
    clear_in();
  endtask

  task automatic test_sh();
    clear_in();
    inResult    = 64'h2006;
    inDataReg2  = 64'hBEEF;
    inMemWrite  = 1'b1;
    inStoreType = 2'b01;
    inReqReady  = 1'b1;
    #1;
    checks++;
    if (outReqWstrb !== 8'hC0 || outReqWdata !== 64'hBEEF_BEEF_BEEF_BEEF ||
        outReqWrite !== 1'b1 || outReqAddr !== 64'h2000) begin
      errors++;
      $display("FAIL sh_fmt strb %h data %h wr %b addr %h want c0 beef.. 1 2000",
               outReqWstrb, outReqWdata, outReqWrite, outReqAddr);
    end
    tick();
    inReqReady  = 1'b0;
    inRespValid = 1'b1;
    tick();
    inRespValid = 1'b0;
    tick();
    checks++;
    if (outAluResult !== 64'h2006 || outMemData !== 64'h0 || outMisaligned !== 1'b0) begin
      errors++;
      $display("FAIL sh_mwb alu %h mem %h mis %b want 2006 0 0",
               outAluResult, outMemData, outMisaligned);
    end
    clear_in();
  endtask

  task automatic test_ready_wait();
    int scnt;
    int acc;
    int bad;
    scnt = 0;
    acc  = 0;
    bad  = 0;
    clear_in();
    inResult       = 64'h4008;
    inMemRead      = 1'b1;
    inLoadType     = 3'b011;
    inRegWrite     = 1'b1;
    inDestRegister = 5'd7;
    for (int i = 0; i < 6; i++) begin
      inReqReady  = (i == 3);
      inRespValid = (i == 4);
      inRespData  = (i == 4) ? 64'h1122_3344_5566_7788 : 64'h0;
      #1;
      if (out_stall_from_dcache) scnt++;
      if (outReqValid && inReqReady) acc++;
      if (i < 4 && (outReqValid !== 1'b1 || outReqAddr !== 64'h4008 ||
                    outReqWrite !== 1'b0)) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ld_stable unstable cycles %0d want 0", bad);
    end
    checks++;
    if (scnt != 5) begin
      errors++;
      $display("FAIL ld_stall cycles %0d want 5", scnt);
    end
    checks++;
    if (acc != 1) begin
      errors++;
      $display("FAIL ld_accept count %0d want 1", acc);
    end
    checks++;
    if (outMemData !== 64'h1122_3344_5566_7788 || outDestRegister !== 5'd7) begin
      errors++;
      $display("FAIL ld_data got %h rd %0d want 1122334455667788 7",
               outMemData, outDestRegister);
    end
    clear_in();
  endtask

  task automatic test_misaligned();
    clear_in();
    inResult   = 64'h3002;
    inMemRead  = 1'b1;
    inLoadType = 3'b010;
    inRegWrite = 1'b1;
    inReqReady = 1'b1;
    #1;
    checks++;
    if (outReqValid !== 1'b0 || out_stall_from_dcache !== 1'b0) begin
      errors++;
      $display("FAIL mis_req valid %b stall %b want 0 0",
               outReqValid, out_stall_from_dcache);
    end
    tick();
    checks++;
    if (outMisaligned !== 1'b1 || outRegWrite !== 1'b0 || outMemData !== 64'h0) begin
      errors++;
      $display("FAIL mis_mwb mis %b rw %b mem %h want 1 0 0",
               outMisaligned, outRegWrite, outMemData);
    end
    clear_in();
  endtask

  task automatic test_reset_wait();
    clear_in();
    inResult   = 64'h5000;
    inMemRead  = 1'b1;
    inLoadType = 3'b010;
    inRegWrite = 1'b1;
    inReqReady = 1'b1;
    tick();
    reset_n = 1'b0;
    clear_in();
    #1;
    checks++;
    if (outReqValid !== 1'b0 || out_stall_from_dcache !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_req valid %b stall %b want 0 0",
               outReqValid, out_stall_from_dcache);
    end
    checks++;
    if (outAluResult !== 64'h0 || outMisaligned !== 1'b0 || outRegWrite !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_mwb alu %h mis %b rw %b want 0 0 0",
               outAluResult, outMisaligned, outRegWrite);
    end
    tick();
    reset_n     = 1'b1;
    inRespValid = 1'b1;
    inRespData  = 64'hFFFF_0000_FFFF_0000;
    tick();
    inRespValid = 1'b0;
    #1;
    checks++;
    if (outMemData !== 64'h0 || outRegWrite !== 1'b0) begin
      errors++;
      $display("FAIL rst_resp mem %h rw %b want 0 0", outMemData, outRegWrite);
    end
    inResult   = 64'h10;
    inMemRead  = 1'b1;
    inLoadType = 3'b000;
    #1;
    checks++;
    if (outReqValid !== 1'b1 || out_stall_from_dcache !== 1'b1) begin
      errors++;
      $display("FAIL rst_idle valid %b stall %b want 1 1",
               outReqValid, out_stall_from_dcache);
    end
    clear_in();
    tick();
  endtask

  task automatic test_icache_done();
    int reqs;
    reqs = 0;
    clear_in();
    inResult       = 64'h6000;
    inMemRead      = 1'b1;
    inLoadType     = 3'b011;
    inRegWrite     = 1'b1;
    inDestRegister = 5'd12;
    inReqReady     = 1'b1;
    #1;
    if (outReqValid) reqs++;
    tick();
    inReqReady  = 1'b0;
    inRespValid = 1'b1;
    inRespData  = 64'hDEAD_BEEF_CAFE_F00D;
    tick();
    inRespValid = 1'b0;
    in_stall_from_icache = 1'b1;
    #1;
    checks++;
    if (out_stall_from_dcache !== 1'b0) begin
      errors++;
      $display("FAIL ic_done_stall got %b want 0", out_stall_from_dcache);
    end
    for (int i = 0; i < 2; i++) begin
      inReqReady = 1'b1;
      #1;
      if (outReqValid) reqs++;
      tick();
    end
    checks++;
    if (outMemData !== 64'h0 || outDestRegister !== 5'd0) begin
      errors++;
      $display("FAIL ic_hold mem %h rd %0d want 0 0", outMemData, outDestRegister);
    end
    in_stall_from_icache = 1'b0;
    #1;
    if (outReqValid) reqs++;
    tick();
    checks++;
    if (reqs != 1) begin
      errors++;
      $display("FAIL ic_reissue requests %0d want 1", reqs);
    end
    checks++;
    if (outMemData !== 64'hDEAD_BEEF_CAFE_F00D || outDestRegister !== 5'd12) begin
      errors++;
      $display("FAIL ic_data mem %h rd %0d want deadbeefcafef00d 12",
               outMemData, outDestRegister);
    end
    clear_in();
  endtask

  task automatic test_back_to_back();
    clear_in();
    inResult   = 64'h7001;
    inMemRead  = 1'b1;
    inLoadType = 3'b100;
    inRegWrite = 1'b1;
    inReqReady = 1'b1;
    tick();
    inReqReady  = 1'b0;
    inRespValid = 1'b1;
    inRespData  = 64'h0000_0000_0000_8000;
    tick();
    inRespValid = 1'b0;
    tick();
    checks++;
    if (outMemData !== 64'h80) begin
      errors++;
      $display("FAIL b2b_lbu got %h want 80", outMemData);
    end
    clear_in();
    inResult    = 64'h7004;
    inDataReg2  = 64'h1234_5678;
    inMemWrite  = 1'b1;
    inStoreType = 2'b10;
    inReqReady  = 1'b1;
    #1;
    checks++;
    if (outReqValid !== 1'b1 || outReqWstrb !== 8'hF0 ||
        outReqWdata !== 64'h1234_5678_1234_5678) begin
      errors++;
      $display("FAIL b2b_sw valid %b strb %h data %h want 1 f0 1234567812345678",
               outReqValid, outReqWstrb, outReqWdata);
    end
    tick();
    inReqReady  = 1'b0;
    inRespValid = 1'b1;
    tick();
    inRespValid = 1'b0;
    tick();
    checks++;
    if (outAluResult !== 64'h7004 || outMemData !== 64'h0) begin
      errors++;
      $display("FAIL b2b_sw_mwb alu %h mem %h want 7004 0", outAluResult, outMemData);
    end
    clear_in();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_passthrough();
    test_lb();
    test_sh();
    test_ready_wait();
    test_misaligned();
    test_reset_wait();
    test_icache_done();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
